// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: instruction geometry, opcode constants and
// the entry format carried from fetch to decode.
package fetch_queue_pkg;

  localparam int INSTR_W     = 32;
  localparam int IMEM_ADDR_W = 7;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head is read
// combinationally from registered storage.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPush = push && !flush;
  assign doPop  = pop && (count != '0) && !flush;
  assign dout   = store[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the decode-facing outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (doPush) begin
      store[wrPtr] <= din;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: owns the PC and instruction memory, prefetches into a
// small queue and hands {instr, PC+1} to decode over valid/ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int IMEM_DEPTH = 128,
  parameter int Q_DEPTH    = 2,
  parameter int DATA_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   writeEnable,
  input  logic [IMEM_ADDR_W-1:0] instructionAddress,
  input  logic [DATA_W-1:0]      instruction,
  input  logic                   redirect_valid,
  input  logic [DATA_W-1:0]      redirect_pc,
  input  logic                   fd_ready,
  output logic                   fd_valid,
  output logic [DATA_W-1:0]      fd_instr,
  output logic [DATA_W-1:0]      fd_pc,
  output logic [DATA_W-1:0]      pc_out
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam int CNT_W = $clog2(Q_DEPTH + 1);

  logic [DATA_W-1:0] mem [IMEM_DEPTH];
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] rdData_p1;
  logic [DATA_W-1:0] tag_p1;
  logic              vld_p1;
  logic              flush;
  logic              pop;
  logic              issue;
  logic              push;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  fetch_entry_t      tailEntry;
  fetch_entry_t      headEntry;

  assign flush     = writeEnable || redirect_valid;
  assign fd_valid  = (count != '0);
  assign pop       = fd_valid && fd_ready;
  // Slots already spoken for after this edge: queued + in flight - leaving.
  assign occupancy = {1'b0, count} + (CNT_W + 1)'(vld_p1) - (CNT_W + 1)'(pop);
  assign issue     = !flush && (occupancy < (CNT_W + 1)'(Q_DEPTH));
  assign push      = vld_p1 && !flush;

  // p0: issue the read of mem[pc] and advance the PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (writeEnable)         pc <= '0;
      else if (redirect_valid) pc <= redirect_pc;
      else if (issue)          pc <= pc + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (writeEnable) mem[instructionAddress] <= instruction;
    if (issue) begin
      rdData_p1 <= mem[pc[IDX_W-1:0]];
      tag_p1    <= pc + DATA_W'(1);
    end
  end

  // p1: read returns and is pushed into the prefetch queue unless flushed
  assign tailEntry = '{instr: rdData_p1, pc_plus1: tag_p1};

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (tailEntry),
    .dout  (headEntry),
    .count (count)
  );

  assign fd_instr = headEntry.instr;
  assign fd_pc    = headEntry.pc_plus1;
  assign pc_out   = pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-level reference model predicts
// deliveries; a negedge monitor consumes them as decode accepts entries.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        writeEnable = 1'b0;
  logic [6:0]  instructionAddress = '0;
  logic [31:0] instruction = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fd_ready = 1'b0;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .writeEnable        (writeEnable),
    .instructionAddress (instructionAddress),
    .instruction        (instruction),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .fd_ready           (fd_ready),
    .fd_valid           (fd_valid),
    .fd_instr           (fd_instr),
    .fd_pc              (fd_pc),
    .pc_out             (pc_out)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp1;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mmem [128];
  logic [31:0] img  [128];
  logic [31:0] mpc = '0;
  bit          infl = 1'b0;
  exp_t        inflEntry;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: fetch state as a queue of pending deliveries, one
  // outstanding read, and the PC. Called once per rising edge.
  task automatic modelEdge();
    bit   flushNow;
    bit   issueNow;
    exp_t nx;
    flushNow = writeEnable || redirect_valid;
    // expQ already excludes the entry decode accepted at this edge.
    issueNow = !flushNow && ((expQ.size() + int'(infl)) < QD);
    if (issueNow) nx = '{mmem[mpc[6:0]], mpc + 32'd1};
    if (flushNow) expQ.delete();
    else if (infl) expQ.push_back(inflEntry);
    infl = issueNow;
    if (issueNow) inflEntry = nx;
    if (writeEnable) begin
      mmem[instructionAddress] = instruction;
      mpc = 32'd0;
    end else if (redirect_valid) begin
      mpc = redirect_pc;
    end else if (issueNow) begin
      mpc = mpc + 32'd1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        expQ.delete();
        mpc  = 32'd0;
        infl = 1'b0;
      end else begin
        modelEdge();
      end
    end
  end

  // Monitor: compares presented outputs and consumes the head on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      check("fd_valid", 32'(fd_valid), 32'(expQ.size() != 0));
      check("pc_out", pc_out, mpc);
      if (expQ.size() != 0) begin
        check("fd_instr", fd_instr, expQ[0].instr);
        check("fd_pc", fd_pc, expQ[0].pcp1);
        if (fd_ready) void'(expQ.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [6:0] a, input logic [31:0] d);
    writeEnable        = 1'b1;
    instructionAddress = a;
    instruction        = d;
    cyc(1);
  endtask

  task automatic expectHead(input string tag, input logic [31:0] ins, input logic [31:0] p);
    check({tag, "_valid"}, 32'(fd_valid), 32'd1);
    check({tag, "_instr"}, fd_instr, ins);
    check({tag, "_pc"}, fd_pc, p);
  endtask

  initial begin
    int r;
    for (int i = 0; i < 128; i++) img[i] = $urandom;
    img[0]   = 32'h2001_0005;
    img[1]   = 32'h2002_0003;
    img[2]   = 32'h0022_1820;
    img[3]   = 32'h8C04_0000;
    img[16]  = 32'h2003_0010;
    img[127] = 32'hAC05_007F;

    // Reset values
    #12;
    check("rst_fd_valid", 32'(fd_valid), 32'd0);
    check("rst_fd_instr", fd_instr, 32'd0);
    check("rst_fd_pc", fd_pc, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    writeEnable        = 1'b1;
    instructionAddress = 7'd0;
    instruction        = img[0];
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 128; i++) loadWord(7'(i), img[i]);
    writeEnable = 1'b0;
    fd_ready    = 1'b1;

    // First instruction two edges after release, then one per cycle
    cyc(1);
    check("first_lat_valid", 32'(fd_valid), 32'd0);
    cyc(1);
    expectHead("seq0", img[0], 32'd1);
    cyc(1);
    expectHead("seq1", img[1], 32'd2);
    cyc(1);
    expectHead("seq2", img[2], 32'd3);
    cyc(1);
    expectHead("seq3", img[3], 32'd4);

    // Stall until full, then redirect to 0x10 with the queue full
    fd_ready = 1'b0;
    cyc(6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    cyc(1);
    redirect_valid = 1'b0;
    check("redir_flush_valid", 32'(fd_valid), 32'd0);
    cyc(1);
    check("redir_gap_valid", 32'(fd_valid), 32'd0);
    cyc(1);
    expectHead("redir16", img[16], 32'h11);
    cyc(3);

    // Redirect on the same edge as a pop, to 0x7F: index wraps, PC does not
    fd_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7F;
    cyc(1);
    redirect_valid = 1'b0;
    check("redir7f_flush_valid", 32'(fd_valid), 32'd0);
    cyc(2);
    expectHead("wrap127", img[127], 32'h80);
    cyc(1);
    expectHead("wrap0", img[0], 32'h81);

    // Redirect and load on the same edge: load wins
    writeEnable        = 1'b1;
    instructionAddress = 7'd0;
    instruction        = img[0];
    redirect_valid     = 1'b1;
    redirect_pc        = 32'h55;
    cyc(1);
    writeEnable    = 1'b0;
    redirect_valid = 1'b0;
    check("load_wins_pc", pc_out, 32'd0);
    cyc(2);
    expectHead("load_wins", img[0], 32'd1);

    // Randomised traffic: back-pressure, redirects, short reloads
    for (int c = 0; c < 1500; c++) begin
      fd_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      writeEnable    = 1'b0;
      r = $urandom_range(0, 31);
      if (r == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 3))
          0:       redirect_pc = 32'h7F;
          1:       redirect_pc = 32'hFFFF_FFFF;
          2:       redirect_pc = $urandom_range(0, 255);
          default: redirect_pc = $urandom;
        endcase
      end else if (r == 1) begin
        writeEnable        = 1'b1;
        instructionAddress = 7'($urandom_range(32, 126));
        instruction        = $urandom;
        redirect_valid     = ($urandom_range(0, 1) == 1);
        redirect_pc        = $urandom;
      end
      cyc(1);
    end
    writeEnable    = 1'b0;
    redirect_valid = 1'b0;
    fd_ready       = 1'b1;
    cyc(5);

    // Asynchronous reset between edges, then restart from mem[0]
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(fd_valid), 32'd0);
    check("async_rst_pc", pc_out, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1);
    check("restart_lat_valid", 32'(fd_valid), 32'd0);
    cyc(1);
    expectHead("restart0", img[0], 32'd1);
    cyc(1);
    expectHead("restart1", img[1], 32'd2);

    fd_ready = 1'b1;
    cyc(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
